// File: rtl/red_pkg.sv
// red_pkg: shared types and constants for the RED byte-reduction sequencer.
//   red_state_t  : sequencer state encoding
//   RED_STEPS    : number of slice steps per reduction
//   RED_*_W      : operand, byte and nibble widths
//   red_ref()    : plain-arithmetic reference of the reduction result
package red_pkg;

  localparam int RED_STEPS  = 7;
  localparam int RED_W      = 16;
  localparam int RED_BYTE_W = 8;
  localparam int RED_NIB_W  = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A0,
    ST_A1,
    ST_B0,
    ST_B1,
    ST_F0,
    ST_F1,
    ST_F2,
    ST_DONE
  } red_state_t;

  // Sum of the four bytes of a and b, sign- or zero-extended to 16 bits.
  function automatic logic [RED_W-1:0] red_ref(input logic [RED_W-1:0] a,
                                               input logic [RED_W-1:0] b,
                                               input logic signed_mode);
    logic [11:0] s;
    s = {{4{signed_mode & a[15]}}, a[15:8]} + {{4{signed_mode & a[7]}}, a[7:0]}
      + {{4{signed_mode & b[15]}}, b[15:8]} + {{4{signed_mode & b[7]}}, b[7:0]};
    return {{4{signed_mode & s[11]}}, s};
  endfunction

endpackage

// File: rtl/red_seq_if.sv
// red_seq_if: request/result handshake bundle of the RED sequencer.
//   master : execute-stage side (drives operands, flush, out_ready)
//   slave  : sequencer side (drives in_ready, out_valid, result)
interface red_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;

  modport master (output in_valid, a, b, flush, out_ready,
                  input  in_ready, out_valid, result);
  modport slave  (input  in_valid, a, b, flush, out_ready,
                  output in_ready, out_valid, result);
endinterface

// File: rtl/red_seq_cla.sv
// CLA_adder_4: 4-bit carry-lookahead adder slice.
//   a, b : nibble operands    cin  : carry in
//   sum  : nibble sum         cout : carry out
module CLA_adder_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/red_seq.sv
// red_seq: multi-cycle RED byte reduction using one shared 4-bit CLA slice.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : red_seq_if.slave (in_valid/in_ready/a/b/flush,
//                out_valid/out_ready/result)
//   SIGNED     : 1 = signed byte sum, sign-extended; 0 = unsigned, zero-extended
// Optional build macro RED_SEQ_B2B_EN: accept the next request in DONE while
// the current result is handed off, skipping the IDLE cycle.
module red_seq
  import red_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  red_seq_if.slave bus
);

  red_state_t        state_q, state_d;
  logic [RED_W-1:0]  a_q, a_d, b_q, b_d;
  logic [8:0]        sa_q, sa_d, sb_q, sb_d;
  logic              carry_q, carry_d;
  logic [RED_W-1:0]  result_q, result_d;

  logic              in_ready, out_valid, accept;
  logic [RED_NIB_W-1:0] add_a, add_b, add_sum;
  logic              add_cin, add_cout;

  CLA_adder_4 u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      carry_q  <= carry_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = ST_A0;
        ST_A0:   state_d = ST_A1;
        ST_A1:   state_d = ST_B0;
        ST_B0:   state_d = ST_B1;
        ST_B1:   state_d = ST_F0;
        ST_F0:   state_d = ST_F1;
        ST_F1:   state_d = ST_F2;
        ST_F2:   state_d = ST_DONE;
        // accept can only be true here in the back-to-back build
        ST_DONE: if (bus.out_ready) state_d = accept ? ST_A0 : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
`ifdef RED_SEQ_B2B_EN
        in_ready = bus.out_ready;
`else
        in_ready = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  assign accept        = bus.in_valid && in_ready && !bus.flush;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;

  // Slice operand/cin muxing and partial-result capture. A flush suppresses
  // every datapath update so an aborted operation leaves nothing behind.
  always_comb begin
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    a_d      = a_q;
    b_d      = b_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    carry_d  = carry_q;
    result_d = result_q;

    case (state_q)
      ST_A0: begin add_a = a_q[3:0];  add_b = a_q[11:8];  end
      ST_A1: begin add_a = a_q[7:4];  add_b = a_q[15:12]; add_cin = carry_q; end
      ST_B0: begin add_a = b_q[3:0];  add_b = b_q[11:8];  end
      ST_B1: begin add_a = b_q[7:4];  add_b = b_q[15:12]; add_cin = carry_q; end
      ST_F0: begin add_a = sa_q[3:0]; add_b = sb_q[3:0];  end
      ST_F1: begin add_a = sa_q[7:4]; add_b = sb_q[7:4];  add_cin = carry_q; end
      ST_F2: begin
        add_a   = SIGNED ? {4{sa_q[8]}} : {3'b000, sa_q[8]};
        add_b   = SIGNED ? {4{sb_q[8]}} : {3'b000, sb_q[8]};
        add_cin = carry_q;
      end
      default: ;
    endcase

    if (!bus.flush) begin
      if (accept) begin
        a_d = bus.a;
        b_d = bus.b;
      end
      case (state_q)
        ST_A0: begin sa_d[3:0] = add_sum; carry_d = add_cout; end
        ST_A1: begin
          sa_d[7:4] = add_sum;
          // Signed 9-bit sign bit: operand signs xor the carry out of bit 7.
          sa_d[8]   = SIGNED ? (a_q[7] ^ a_q[15] ^ add_cout) : add_cout;
          carry_d   = add_cout;
        end
        ST_B0: begin sb_d[3:0] = add_sum; carry_d = add_cout; end
        ST_B1: begin
          sb_d[7:4] = add_sum;
          sb_d[8]   = SIGNED ? (b_q[7] ^ b_q[15] ^ add_cout) : add_cout;
          carry_d   = add_cout;
        end
        ST_F0: begin result_d[3:0] = add_sum; carry_d = add_cout; end
        ST_F1: begin result_d[7:4] = add_sum; carry_d = add_cout; end
        ST_F2: begin
          result_d[8]    = add_sum[0];
          result_d[15:9] = SIGNED ? {7{add_sum[1]}} : {6'b000000, add_sum[1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_red_seq.sv
// Self-checking bench for red_seq: signed and unsigned instances share stimulus.
module tb_red_seq;
  import red_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  red_seq_if bus_s ();
  red_seq_if bus_u ();

  red_seq #(.SIGNED(1'b1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s.slave));
  red_seq #(.SIGNED(1'b0)) u_dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u.slave));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef RED_SEQ_B2B_EN
  localparam logic B2B = 1'b1;
`else
  localparam logic B2B = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_s;
    logic [15:0] exp_u;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer sum of the four bytes, truncated to 16 bits.
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input bit sgn);
    int s;
    if (sgn) s = int'(byte'(a[15:8])) + int'(byte'(a[7:0]))
               + int'(byte'(b[15:8])) + int'(byte'(b[7:0]));
    else     s = int'(a[15:8]) + int'(a[7:0]) + int'(b[15:8]) + int'(b[7:0]);
    return 16'(s);
  endfunction

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic fl, input logic ordy);
    bus_s.in_valid = v;  bus_u.in_valid = v;
    bus_s.a = a;         bus_u.a = a;
    bus_s.b = b;         bus_u.b = b;
    bus_s.flush = fl;    bus_u.flush = fl;
    bus_s.out_ready = ordy; bus_u.out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request; latency counts the accepting edge as edge 1.
  task automatic run_tx(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_s, input logic [15:0] exp_u,
                        input int stall, input string tag);
    int edges;
    logic leak;
    logic hold_bad;
    logic ordy;
    ordy = (stall == 0);
    drive(1'b1, a, b, 1'b0, ordy);
    step();
    edges = 1;
    leak = 1'b0;
    while (!bus_s.out_valid && edges < 20) begin
      if (bus_s.in_ready || bus_u.in_ready) leak = 1'b1;
      drive(1'b1, 16'($urandom), 16'($urandom), 1'b0, ordy);
      step();
      edges++;
    end
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, ordy);
    chk({tag, " latency"}, 16'(edges), 16'd8);
    chk({tag, " in_ready while busy"}, {15'b0, leak}, 16'h0000);
    chk({tag, " out_valid unsigned"}, {15'b0, bus_u.out_valid}, 16'h0001);
    chk({tag, " result signed"}, bus_s.result, exp_s);
    chk({tag, " result unsigned"}, bus_u.result, exp_u);
    if (stall > 0) begin
      hold_bad = 1'b0;
      for (int i = 0; i < stall; i++) begin
        drive(1'b1, 16'h1111, 16'h1111, 1'b0, 1'b0);
        if (bus_s.in_ready) hold_bad = 1'b1;
        step();
        if (!bus_s.out_valid || bus_s.result !== exp_s || bus_u.result !== exp_u
            || bus_s.in_ready) hold_bad = 1'b1;
      end
      chk({tag, " back-pressure hold"}, {15'b0, hold_bad}, 16'h0000);
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    end else begin
      chk({tag, " in_ready in DONE"}, {15'b0, bus_s.in_ready}, {15'b0, B2B});
    end
    step();
    chk({tag, " out_valid after handoff"}, {15'b0, bus_s.out_valid}, 16'h0000);
    chk({tag, " in_ready after handoff"}, {15'b0, bus_s.in_ready}, 16'h0001);
  endtask

  task automatic watch_no_valid(input int cycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus_s.out_valid || bus_u.out_valid) seen = 1'b1;
    end
    chk({tag, " no out_valid"}, {15'b0, seen}, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    int e;

    tbl[0] = '{16'h0102, 16'h0304, 16'h000A, 16'h000A};
    tbl[1] = '{16'h8080, 16'h8080, 16'hFE00, 16'h0200};
    tbl[2] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h01FF};
    tbl[3] = '{16'h7F7F, 16'h7F7F, 16'h01FC, 16'h01FC};
    tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFC, 16'h03FC};

    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    #12;
    chk("reset out_valid", {15'b0, bus_s.out_valid}, 16'h0000);
    chk("reset result", bus_s.result, 16'h0000);
    #10;
    rst_n = 1'b1;
    step();
    chk("post-reset in_ready", {15'b0, bus_s.in_ready}, 16'h0001);

    for (int i = 0; i < 6; i++)
      run_tx(tbl[i].a, tbl[i].b, tbl[i].exp_s, tbl[i].exp_u, 0, $sformatf("vec%0d", i));

    // Back-pressure for 5 cycles with a competing request presented.
    run_tx(16'h0102, 16'h0304, 16'h000A, 16'h000A, 5, "stall");

    // Flush while in B0.
    drive(1'b1, 16'h0102, 16'h0304, 1'b0, 1'b1);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    step();
    step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("flush B0 in_ready", {15'b0, bus_s.in_ready}, 16'h0001);
    chk("flush B0 out_valid", {15'b0, bus_s.out_valid}, 16'h0000);
    watch_no_valid(12, "flush B0");

    // Flush together with a request in IDLE: request must be dropped.
    drive(1'b1, 16'h0102, 16'h0304, 1'b1, 1'b1);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("flush idle in_ready", {15'b0, bus_s.in_ready}, 16'h0001);
    watch_no_valid(12, "flush idle");

    // Reset pulse while in F1.
    drive(1'b1, 16'h0102, 16'h0304, 1'b0, 1'b1);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    chk("rst F1 out_valid", {15'b0, bus_s.out_valid}, 16'h0000);
    chk("rst F1 result signed", bus_s.result, 16'h0000);
    chk("rst F1 result unsigned", bus_u.result, 16'h0000);
    #1;
    rst_n = 1'b1;
    step();
    chk("rst F1 in_ready", {15'b0, bus_s.in_ready}, 16'h0001);
    watch_no_valid(10, "rst F1");

    // Randomized requests with random back-pressure.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_tx(ra, rb, model(ra, rb, 1'b1), model(ra, rb, 1'b0),
             int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

`ifdef RED_SEQ_B2B_EN
    drive(1'b1, 16'h0102, 16'h0304, 1'b0, 1'b1);
    step();
    e = 1;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    while (!bus_s.out_valid && e < 20) begin step(); e++; end
    chk("b2b first latency", 16'(e), 16'd8);
    chk("b2b first result", bus_s.result, 16'h000A);
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    step();
    e = 1;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("b2b handoff out_valid", {15'b0, bus_s.out_valid}, 16'h0000);
    while (!bus_s.out_valid && e < 20) begin step(); e++; end
    chk("b2b spacing", 16'(e), 16'd8);
    chk("b2b second result signed", bus_s.result, 16'hFFFF);
    chk("b2b second result unsigned", bus_u.result, 16'h01FF);
    step();
`else
    e = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/red_seq.md
Name: red_seq

Overview:
- Multi-cycle sequencer for the RED (byte-reduction) instruction.
- Computes the same result as the combinational reduction unit, but time-multiplexes a single 4-bit CLA slice over 7 steps.
- Sits beside the ALU as a low-area alternative. It has a valid/ready request side and a valid/ready result side toward the execute stage.

Parameters:
- SIGNED, 1, 1 = signed byte reduction per ISA (sign-extended result); 0 = unsigned reduction (zero-extended result).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  sequencer can accept operands
- a  in  16  first operand (bytes a[15:8], a[7:0])
- b  in  16  second operand (bytes b[15:8], b[7:0])
- flush  in  1  synchronous abort; drops any in-flight or pending result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  16  reduction result

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous, active-low.
  - All of the following clear immediately on rst_n low: state, operand registers, partial sums, carry register, result.
  - out_valid=0, result=16'h0000.
  - in_ready=1 once rst_n deasserts.
- Arithmetic (golden model):
  - SIGNED=1: result = sext16(sa(a[15:8])+sa(a[7:0])+sa(b[15:8])+sa(b[7:0])), where sa() is signed byte. Range -512..508, which fits 10 bits.
  - SIGNED=0: result = zext16 of the unsigned four-byte sum. Max 1020.
- FSM states: IDLE, A0, A1, B0, B1, F0, F1, F2, DONE.
  - IDLE: in_ready=1. On in_valid, latch a and b, go to A0.
  - A0: slice computes a[3:0]+a[11:8], cin=0. Latch sum into sa9[3:0] and cout into the carry register.
  - A1: a[7:4]+a[15:12]+carry into sa9[7:4].
    - sa9[8] = a[7]^a[15]^cout when SIGNED=1.
    - sa9[8] = cout when SIGNED=0.
  - B0, B1: identical to A0, A1 on b, producing sb9.
  - F0: sa9[3:0]+sb9[3:0], cin=0, into result[3:0].
  - F1: sa9[7:4]+sb9[7:4]+carry, into result[7:4].
  - F2: operands are {4{sa9[8]}},{4{sb9[8]}} when SIGNED=1, or {3'b0,sa9[8]},{3'b0,sb9[8]} when SIGNED=0; cin=carry, slice output t.
    - result[8]=t[0].
    - result[15:9] = {7{t[1]}} when SIGNED=1, or {7{1'b0}}|t[1] at bit 9 when SIGNED=0.
    - Go to DONE.
  - DONE: out_valid=1, result stable. On out_ready go to IDLE.
- Latency: out_valid rises exactly 8 clock edges after the accepting edge (7 compute edges plus the DONE entry edge). Throughput is 1 result per 9 cycles without the optional feature.
- in_ready=1 only in IDLE. in_valid in any other state is ignored; operands are not captured.
- result is registered and changes only during the F-states. It holds its last value in IDLE.
- flush has priority over all other inputs. Next state is IDLE, out_valid drops, and no result is delivered.
  - flush with in_valid in IDLE: the request is not accepted.
- Back-pressure: out_ready low holds DONE, out_valid and result indefinitely.
- rst_n low in any state aborts the operation. There is no partial result.

Optional Feature:
- RED_SEQ_B2B_EN defined:
  - In DONE, in_ready = out_ready.
  - When out_valid&&out_ready&&in_valid, the new operands are latched and the FSM goes straight to A0. Throughput is 1 per 8 cycles.
- Undefined: in_ready is asserted in IDLE only.

Decomposition:
- Shared package red_pkg holds:
  - the state enum red_state_t;
  - localparams RED_STEPS=7 and the byte/nibble widths;
  - a reference function red_ref(a,b,signed_mode) for the bench.
- Sub-module: the existing CLA_adder_4, one instance, with operand and cin muxes driven by the state.
- No second adder is permitted.

Test Plan:
- a=16'h0102, b=16'h0304, in_valid pulse, out_ready=1 → out_valid 8 edges later, result=16'h000A, back in IDLE next cycle.
- SIGNED=1: a=16'h8080, b=16'h8080 → 16'hFE00. SIGNED=0, same operands → 16'h0200.
- SIGNED=1: a=16'hFFFF, b=16'h0001 → 16'hFFFF. a=16'h7F7F, b=16'h7F7F → 16'h01FC.
- out_ready=0 for 5 cycles in DONE with in_valid=1, a=16'h1111 → out_valid and result held, in_ready=0, new operands ignored. Result 16'h000A is delivered when out_ready rises.
- flush during B0 → IDLE next edge, out_valid never asserts, in_ready=1. rst_n pulsed low during F1 → out_valid=0 and result=0 immediately.
- RED_SEQ_B2B_EN: two back-to-back requests (0x0102/0x0304, then 0xFFFF/0x0001) → results 16'h000A, 16'hFFFF with out_valid edges 8 cycles apart.
